// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick and bit tick with a glitch-free divisor reload.
// Define BAUD_GEN_FRAC_EN to include the fractional accumulator; otherwise the period is exactly div_a.
module baud_gen_frac #(
  parameter int N          = 16,
  parameter int F          = 4,
  parameter int OVS        = 16,
  parameter int RESET_DIV  = 163,
  parameter int RESET_FRAC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync_clr,
  input  logic [N-1:0] div_int,
  input  logic [F-1:0] div_frac,
  input  logic         div_load,
  output logic         cfg_ack,
  output logic         s_tick,
  output logic         bit_tick,
  output logic [N-1:0] q
);
  localparam int OW = $clog2(OVS);

  logic [N-1:0]  cnt;
  logic [N-1:0]  div_a;
  logic [N-1:0]  div_p;
  logic [N-1:0]  div_new;
  logic [N-1:0]  term;
  logic [OW-1:0] ovs;
  logic          pend;
  logic          ext;
  logic          apply;

  function automatic logic [N-1:0] clamp_div(input logic [N-1:0] d);
    return (d < N'(2)) ? N'(2) : d;
  endfunction

  assign term     = div_a - N'(1) + {{(N-1){1'b0}}, ext};
  assign s_tick   = en & (cnt == term);
  assign bit_tick = s_tick & (ovs == OW'(OVS - 1));
  assign q        = cnt;

  // A pending divisor only takes effect at a period boundary or while frozen.
  assign apply    = (pend | div_load) & (s_tick | ~en);
  assign div_new  = div_load ? clamp_div(div_int) : div_p;

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      cnt <= '0;
      ovs <= '0;
    end else if (en) begin
      if (s_tick) begin
        cnt <= '0;
        ovs <= (ovs == OW'(OVS - 1)) ? '0 : ovs + OW'(1);
      end else begin
        cnt <= cnt + N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (div_load) div_p <= clamp_div(div_int);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_a   <= N'(RESET_DIV);
      pend    <= 1'b0;
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= apply;
      if (apply) begin
        div_a <= div_new;
        pend  <= 1'b0;
      end else if (div_load) begin
        pend  <= 1'b1;
      end
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [F-1:0] acc;
  logic [F-1:0] frac_a;
  logic [F-1:0] frac_p;
  logic [F-1:0] frac_new;
  logic [F:0]   acc_sum;

  // The carry out of the accumulator stretches the following period by one cycle.
  assign acc_sum  = {1'b0, acc} + {1'b0, frac_a};
  assign frac_new = div_load ? div_frac : frac_p;

  always_ff @(posedge clk) begin
    if (div_load) frac_p <= div_frac;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frac_a <= F'(RESET_FRAC);
    end else if (apply) begin
      frac_a <= frac_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (s_tick) begin
      acc <= acc_sum[F-1:0];
      ext <= acc_sum[F];
    end
  end
`else
  logic unused_cfg;

  assign ext        = 1'b0;
  assign unused_cfg = ^{div_frac, F'(RESET_FRAC)};
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: cycle-level arithmetic model plus directed scenarios with literal expectations.
module tb_baud_gen_frac;
  localparam int N    = 16;
  localparam int F    = 4;
  localparam int OVS  = 16;
  localparam int RDIV = 163;
`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sync_clr = 1'b0;
  logic         div_load = 1'b0;
  logic [N-1:0] div_int = '0;
  logic [F-1:0] div_frac = '0;
  logic         cfg_ack;
  logic         s_tick;
  logic         bit_tick;
  logic [N-1:0] q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_q[$];
  int bit_q[$];
  int ack_q[$];

  // Model state: plain integers, period length = divisor + carry of the fraction sum.
  int m_cnt, m_ovs, m_acc, m_ext, m_div, m_frac, m_pend, m_pdiv, m_pfrac, m_ack;
  bit m_valid = 1'b0;

  baud_gen_frac #(.N(N), .F(F), .OVS(OVS), .RESET_DIV(RDIV), .RESET_FRAC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .cfg_ack(cfg_ack), .s_tick(s_tick), .bit_tick(bit_tick), .q(q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tk(input int i);
    return (i >= 0 && i < tick_q.size()) ? tick_q[i] : -1000000;
  endfunction

  always @(negedge clk) begin : cmp
    bit e_s, e_b, apply;
    int nd, nf;
    e_s = en && (m_cnt == m_div + m_ext - 1);
    e_b = e_s && (m_ovs == OVS - 1);
    if (m_valid) begin
      check("s_tick", s_tick, e_s);
      check("bit_tick", bit_tick, e_b);
      check("q", q, m_cnt);
      check("cfg_ack", cfg_ack, m_ack);
    end
    if (s_tick) tick_q.push_back(cyc);
    if (bit_tick) bit_q.push_back(cyc);
    if (cfg_ack) ack_q.push_back(cyc);
    if (rst) begin
      m_cnt = 0; m_ovs = 0; m_acc = 0; m_ext = 0; m_pend = 0; m_ack = 0;
      m_div = RDIV; m_frac = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      apply = (m_pend != 0 || div_load) && (e_s || !en);
      if (sync_clr) begin
        m_cnt = 0; m_ovs = 0; m_acc = 0; m_ext = 0;
      end else if (en) begin
        if (e_s) begin
          m_cnt = 0;
          m_ovs = (m_ovs + 1) % OVS;
          if (FRAC_ON) begin
            m_acc = m_acc + m_frac;
            m_ext = (m_acc >= (1 << F)) ? 1 : 0;
            m_acc = m_acc % (1 << F);
          end
        end else begin
          m_cnt = (m_cnt + 1) % (1 << N);
        end
      end
      nd = (int'(div_int) < 2) ? 2 : int'(div_int);
      nf = int'(div_frac);
      if (apply) begin
        m_div  = div_load ? nd : m_pdiv;
        m_frac = div_load ? nf : m_pfrac;
        m_pend = 0;
      end else if (div_load) begin
        m_pdiv = nd; m_pfrac = nf; m_pend = 1;
      end
      m_ack = apply ? 1 : 0;
    end
    cyc++;
  end

  // what: 0 q==v, 1 cfg_ack, 2 s_tick, 3 bit_tick; polled just after the active edge.
  task automatic wait_for(input int what, input int v, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if ((what == 0 && int'(q) == v) || (what == 1 && cfg_ack) ||
          (what == 2 && s_tick) || (what == 3 && bit_tick)) return;
      @(posedge clk); #1;
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, lc, nt, a0;
    step(3);
    rst = 1'b0;
    check("rst_q", q, 0);
    check("rst_s_tick", s_tick, 0);
    check("rst_cfg_ack", cfg_ack, 0);

    // Reset divisor, free running.
    en = 1'b1; base = cyc; tick_q.delete(); bit_q.delete();
    step(3000);
    check("def_tick_count", tick_q.size(), 18);
    check("def_first_tick", tk(0) - base, 162);
    check("def_period", tk(1) - tk(0), 163);
    check("def_bit_count", bit_q.size(), 1);
    check("def_bit_pos", (bit_q.size() > 0) ? bit_q[0] - base : -1, 2607);
    check("def_q_after", q, 66);

    // Frozen load of 10 + 8/16 together with a phase clear.
    en = 1'b0; sync_clr = 1'b1; div_load = 1'b1; div_int = 16'd10; div_frac = 4'd8;
    step(1);
    div_load = 1'b0; sync_clr = 1'b0;
    check("frz_ack", cfg_ack, 1);
    check("frz_q", q, 0);
    en = 1'b1; base = cyc; tick_q.delete();
    step(200);
    check("frac_first", tk(0) - base, 9);
    check("frac_span16", tk(16) - tk(0), FRAC_ON ? 168 : 160);

    // Back to 163, then load 20 mid-period.
    en = 1'b0; sync_clr = 1'b1; div_load = 1'b1; div_int = 16'd163; div_frac = 4'd0;
    step(1);
    div_load = 1'b0; sync_clr = 1'b0; en = 1'b1;
    wait_for(0, 50, 300, "q50");
    lc = cyc; tick_q.delete(); ack_q.delete();
    div_load = 1'b1; div_int = 16'd20;
    step(1);
    div_load = 1'b0;
    wait_for(1, 0, 300, "ack20");
    check("mid_tick_at", tk(0) - lc, 112);
    check("mid_ack_at", cyc - tk(0), 1);
    // Two loads before the next boundary; only the second (clamped to 2) applies.
    div_load = 1'b1; div_int = 16'd5;
    step(1);
    div_int = 16'd1;
    step(1);
    div_load = 1'b0;
    step(40);
    check("per20", tk(1) - tk(0), 20);
    check("per2_a", tk(2) - tk(1), 2);
    check("per2_b", tk(3) - tk(2), 2);
    check("ack_count", ack_q.size(), 2);
    check("ack2_at", (ack_q.size() > 1) ? ack_q[1] - tk(1) : -1, 1);

    // Running load of 163, then freeze mid-period.
    div_load = 1'b1; div_int = 16'd163;
    step(1);
    div_load = 1'b0;
    wait_for(1, 0, 10, "ack163");
    wait_for(0, 60, 300, "q60");
    en = 1'b0; nt = tick_q.size();
    step(40);
    check("hold_q", q, 60);
    check("hold_no_tick", tick_q.size(), nt);
    en = 1'b1; base = cyc;
    step(110);
    check("resume_tick", tk(nt) - base, 102);

    // Phase clear with ovs=7, cnt=80.
    wait_for(3, 0, 3000, "bit");
    for (int i = 0; i < 7; i++) begin
      step(1);
      wait_for(2, 0, 300, "tick");
    end
    step(1);
    wait_for(0, 80, 300, "q80");
    sync_clr = 1'b1; lc = cyc;
    step(1);
    sync_clr = 1'b0;
    check("clr_q", q, 0);
    nt = tick_q.size(); bit_q.delete();
    step(2620);
    check("clr_tick", tk(nt) - lc, 163);
    check("clr_bit", (bit_q.size() > 0) ? bit_q[bit_q.size() - 1] - lc : -1, 2608);

    // Reset with a pending load.
    wait_for(0, 100, 300, "q100");
    div_load = 1'b1; div_int = 16'd20;
    step(1);
    div_load = 1'b0; rst = 1'b1; a0 = ack_q.size();
    step(1);
    rst = 1'b0;
    check("rst2_q", q, 0);
    check("rst2_ack", cfg_ack, 0);
    base = cyc; nt = tick_q.size();
    step(200);
    check("rst2_no_ack", ack_q.size(), a0);
    check("rst2_tick", tk(nt) - base, 162);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
